// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_arbiter
// Purpose  : Round-robin arbiter sharing one memory bus among NUM_MASTERS
//            requesters. A granted transaction holds the bus until the slave
//            asserts ready_in; a completing cycle re-arbitrates in place so
//            back-to-back transfers run with no idle cycle.
// Options  : RR_BUS_ARBITER_TIMEOUT_EN - force an error completion after
//            TIMEOUT_CYCLES bus cycles without slave ready.
// Revision : 1.0 - initial release
// ============================================================================
module rr_bus_arbiter #(
   parameter int NUM_MASTERS    = 3,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [32*NUM_MASTERS-1:0]   m_address_in,
   input  logic [NUM_MASTERS-1:0]      m_read_in,
   input  logic [NUM_MASTERS-1:0]      m_write_in,
   input  logic [4*NUM_MASTERS-1:0]    m_write_mask_in,
   input  logic [32*NUM_MASTERS-1:0]   m_write_value_in,
   output logic [31:0]                 m_read_value_out,
   output logic [NUM_MASTERS-1:0]      m_ready_out,
   output logic                        m_error_out,
   output logic [31:0]                 address_out,
   output logic                        read_out,
   output logic                        write_out,
   output logic [3:0]                  write_mask_out,
   output logic [31:0]                 write_value_out,
   input  logic [31:0]                 read_value_in,
   input  logic                        ready_in
);

   localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]             state_q, state_d;
   logic [GW-1:0]          grant_q, grant_d;
   logic [GW-1:0]          last_q, last_d;

   logic                   busy_w;
   logic                   done_w;
   logic                   timeout_hit_w;
   logic                   new_grant_w;
   logic [NUM_MASTERS-1:0] req_w;
   logic [NUM_MASTERS-1:0] arb_req_w;
   logic                   win_found_w;
   logic [GW-1:0]          win_w;
   logic [31:0]            sel_addr_w;
   logic [31:0]            sel_wdata_w;
   logic [3:0]             sel_mask_w;
   logic                   sel_rd_w;
   logic                   sel_wr_w;

   assign busy_w = (state_q == S_BUSY);
   assign req_w  = m_read_in | m_write_in;
   assign done_w = busy_w & (ready_in | timeout_hit_w);

   // Select the granted master's bus signals; the completing master's own
   // strobes are masked out so it cannot win the same-cycle re-arbitration.
   always_comb begin
      sel_addr_w  = '0;
      sel_wdata_w = '0;
      sel_mask_w  = '0;
      sel_rd_w    = 1'b0;
      sel_wr_w    = 1'b0;
      arb_req_w   = req_w;
      m_ready_out = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q == GW'(i)) begin
            sel_addr_w     = m_address_in[32*i +: 32];
            sel_wdata_w    = m_write_value_in[32*i +: 32];
            sel_mask_w     = m_write_mask_in[4*i +: 4];
            sel_rd_w       = m_read_in[i];
            sel_wr_w       = m_write_in[i];
            arb_req_w[i]   = req_w[i] & ~busy_w;
            m_ready_out[i] = done_w;
         end
      end
   end

   // Rotating search for the next requester, starting just after last grant.
   always_comb begin
      int unsigned idx;
      logic [GW-1:0] idx_g;
      win_found_w = 1'b0;
      win_w       = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx   = (32'(last_q) + 32'(k)) % 32'(NUM_MASTERS);
         idx_g = idx[GW-1:0];
         if (!win_found_w && arb_req_w[idx_g]) begin
            win_found_w = 1'b1;
            win_w       = idx_g;
         end
      end
   end

   // Bus outputs follow the granted master while BUSY and are zero in IDLE;
   // a combined read+write request is treated as a write.
   always_comb begin
      address_out      = busy_w ? sel_addr_w  : 32'h0;
      write_value_out  = busy_w ? sel_wdata_w : 32'h0;
      write_mask_out   = busy_w ? sel_mask_w  : 4'h0;
      write_out        = busy_w & sel_wr_w;
      read_out         = busy_w & sel_rd_w & ~sel_wr_w;
      m_read_value_out = !busy_w ? 32'h0 :
                         timeout_hit_w ? 32'hFFFF_FFFF : read_value_in;
   end

   // Grant state machine: IDLE grants next cycle, BUSY completes on ready and
   // hands over directly to the next winner if one is pending.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      new_grant_w = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_found_w) begin
               state_d     = S_BUSY;
               grant_d     = win_w;
               last_d      = win_w;
               new_grant_w = 1'b1;
            end
         end
         S_BUSY: begin
            if (done_w) begin
               if (win_found_w) begin
                  grant_d     = win_w;
                  last_d      = win_w;
                  new_grant_w = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers; reset leaves master 0 as the first winner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= GW'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef RR_BUS_ARBITER_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] tcnt_q, tcnt_d;

   assign timeout_hit_w = busy_w & ~ready_in & (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
   assign m_error_out   = timeout_hit_w;

   // Wait-state counter: cleared on every new grant, counts unready BUSY cycles.
   always_comb begin
      tcnt_d = tcnt_q;
      if (new_grant_w) begin
         tcnt_d = '0;
      end else if (busy_w && !ready_in) begin
         tcnt_d = tcnt_q + TW'(1);
      end
   end

   // Wait-state counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`else
   assign timeout_hit_w = 1'b0;
   assign m_error_out   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_bus_arbiter
// Purpose  : Directed bench for rr_bus_arbiter with a cycle-level reference
//            model of the round-robin rules and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_bus_arbiter;

   localparam int N  = 3;
   localparam int TC = 8;
`ifdef RR_BUS_ARBITER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [32*N-1:0] m_address_in;
   logic [N-1:0]    m_read_in;
   logic [N-1:0]    m_write_in;
   logic [4*N-1:0]  m_write_mask_in;
   logic [32*N-1:0] m_write_value_in;
   logic [31:0]     m_read_value_out;
   logic [N-1:0]    m_ready_out;
   logic            m_error_out;
   logic [31:0]     address_out;
   logic            read_out;
   logic            write_out;
   logic [3:0]      write_mask_out;
   logic [31:0]     write_value_out;
   logic [31:0]     read_value_in;
   logic            ready_in;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int rec_q[$];

   // model state: owner = granted master or -1 when idle
   int owner = -1;
   int last  = N - 1;
   int cnt   = 0;
   int n_owner = -1;
   int n_last  = N - 1;
   int n_cnt   = 0;

   rr_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TC)) dut (
      .clk(clk), .reset(reset),
      .m_address_in(m_address_in), .m_read_in(m_read_in), .m_write_in(m_write_in),
      .m_write_mask_in(m_write_mask_in), .m_write_value_in(m_write_value_in),
      .m_read_value_out(m_read_value_out), .m_ready_out(m_ready_out),
      .m_error_out(m_error_out), .address_out(address_out), .read_out(read_out),
      .write_out(write_out), .write_mask_out(write_mask_out),
      .write_value_out(write_value_out), .read_value_in(read_value_in),
      .ready_in(ready_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else
         pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int i, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] mk, input logic [31:0] d);
      m_read_in[i]               = rd;
      m_write_in[i]              = wr;
      m_address_in[32*i +: 32]   = a;
      m_write_mask_in[4*i +: 4]  = mk;
      m_write_value_in[32*i +: 32] = d;
   endtask

   function automatic int pick(input logic [N-1:0] r, input int from);
      for (int k = 1; k <= N; k++) begin
         if (r[(from + k) % N]) return (from + k) % N;
      end
      return -1;
   endfunction

   // Reference model: derive expected outputs from the current owner and
   // inputs, compare, record completions, then compute the next owner.
   always @(negedge clk) begin
      logic [N-1:0] req;
      logic [N-1:0] e_rdy;
      logic [31:0]  e_addr, e_wd, e_rv;
      logic [3:0]   e_mask;
      logic         e_rd, e_wr, e_err, done;
      int           w;
      req = m_read_in | m_write_in;
      e_rdy = '0; e_addr = '0; e_wd = '0; e_rv = '0; e_mask = '0;
      e_rd = 1'b0; e_wr = 1'b0; e_err = 1'b0; done = 1'b0;
      if (!reset && owner >= 0) begin
         e_wr   = m_write_in[owner];
         e_rd   = m_read_in[owner] & ~e_wr;
         e_addr = m_address_in[owner*32 +: 32];
         e_wd   = m_write_value_in[owner*32 +: 32];
         e_mask = m_write_mask_in[owner*4 +: 4];
         e_err  = TO_EN && (cnt == TC - 1) && !ready_in;
         done   = ready_in || e_err;
         e_rdy  = done ? (N'(1) << owner) : '0;
         e_rv   = e_err ? 32'hFFFF_FFFF : read_value_in;
      end
      chk("ready",   32'(m_ready_out),    32'(e_rdy));
      chk("error",   32'(m_error_out),    32'(e_err));
      chk("address", address_out,         e_addr);
      chk("read",    32'(read_out),        32'(e_rd));
      chk("write",   32'(write_out),       32'(e_wr));
      chk("mask",    32'(write_mask_out),  32'(e_mask));
      chk("wdata",   write_value_out,      e_wd);
      chk("rvalue",  m_read_value_out,     e_rv);
      for (int i = 0; i < N; i++) if (m_ready_out[i]) rec_q.push_back(i);
      n_owner = owner; n_last = last; n_cnt = cnt;
      if (reset) begin
         n_owner = -1; n_last = N - 1; n_cnt = 0;
      end else if (owner < 0 || done) begin
         if (owner >= 0) req[owner] = 1'b0;
         w = pick(req, last);
         n_owner = w;
         if (w >= 0) begin
            n_last = w; n_cnt = 0;
         end
      end else begin
         n_cnt = cnt + 1;
      end
   end

   // Advance the model on the active edge.
   always @(posedge clk) begin
      owner <= n_owner;
      last  <= n_last;
      cnt   <= n_cnt;
   end

   initial begin
      int exp_order[6];
      exp_order = '{0, 1, 2, 0, 1, 2};
      reset = 1'b1;
      m_address_in = '0; m_read_in = '0; m_write_in = '0;
      m_write_mask_in = '0; m_write_value_in = '0;
      read_value_in = '0; ready_in = 1'b0;
      @(negedge clk);
      chk("reset_ready", 32'(m_ready_out), 32'h0);
      chk("reset_addr", address_out, 32'h0);
      tick(); tick();
      reset = 1'b0;

      // single read with zero-wait slave
      set_m(0, 1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
      ready_in = 1'b1; read_value_in = 32'h1234_5678;
      tick();
      @(negedge clk);
      chk("t1_read", 32'(read_out), 32'h1);
      chk("t1_ready", 32'(m_ready_out), 32'h1);
      chk("t1_rvalue", m_read_value_out, 32'h1234_5678);
      chk("t1_addr", address_out, 32'h10);
      tick();
      set_m(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("t1_idle_read", 32'(read_out), 32'h0);
      chk("t1_idle_ready", 32'(m_ready_out), 32'h0);

      // three continuous requesters, zero-wait slave
      reset = 1'b1; tick(); reset = 1'b0;
      rec_q.delete();
      set_m(0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
      set_m(1, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
      set_m(2, 1'b1, 1'b0, 32'h300, 4'h0, 32'h0);
      repeat (6) tick();
      m_read_in = 3'b100;
      tick();
      m_read_in = 3'b000;
      @(negedge clk);
      chk("t2_count", 32'(rec_q.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < rec_q.size()) chk("t2_order", 32'(rec_q[i]), 32'(exp_order[i]));

      // write with three wait states, master0 arrives mid-transaction
      rec_q.delete();
      ready_in = 1'b0;
      set_m(1, 1'b0, 1'b1, 32'h0001_0000, 4'b0001, 32'hA5);
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 2) set_m(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
         if (c == 4) ready_in = 1'b1;
         @(negedge clk);
         chk("t3_write", 32'(write_out), 32'h1);
         chk("t3_addr", address_out, 32'h0001_0000);
         chk("t3_mask", 32'(write_mask_out), 32'h1);
         chk("t3_data", write_value_out, 32'hA5);
         chk("t3_ready", 32'(m_ready_out), (c == 4) ? 32'h2 : 32'h0);
      end
      tick();
      set_m(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("t3_next_addr", address_out, 32'h20);
      chk("t3_next_ready", 32'(m_ready_out), 32'h1);
      tick();
      set_m(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      ready_in = 1'b0;

      // read and write together: write wins
      set_m(2, 1'b1, 1'b1, 32'h30, 4'hF, 32'hDEAD_BEEF);
      ready_in = 1'b1;
      tick();
      @(negedge clk);
      chk("t4_write", 32'(write_out), 32'h1);
      chk("t4_read", 32'(read_out), 32'h0);
      chk("t4_ready", 32'(m_ready_out), 32'h4);
      tick();
      set_m(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      ready_in = 1'b0;

      // reset during a wait state, then 3-way tie
      set_m(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
      tick(); tick();
      reset = 1'b1;
      set_m(1, 1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
      set_m(2, 1'b1, 1'b0, 32'h48, 4'h0, 32'h0);
      @(negedge clk);
      chk("t5_rst_ready", 32'(m_ready_out), 32'h0);
      chk("t5_rst_addr", address_out, 32'h0);
      chk("t5_rst_read", 32'(read_out), 32'h0);
      tick(); tick();
      reset = 1'b0; ready_in = 1'b1;
      tick();
      m_read_in = 3'b001;
      @(negedge clk);
      chk("t5_tie_winner", 32'(m_ready_out), 32'h1);
      chk("t5_tie_addr", address_out, 32'h40);
      tick();
      m_read_in = 3'b000; ready_in = 1'b0;

      // unresponsive slave
      set_m(1, 1'b1, 1'b0, 32'h50, 4'h0, 32'h0);
      for (int c = 1; c <= 110; c++) begin
         tick();
         @(negedge clk);
`ifdef RR_BUS_ARBITER_TIMEOUT_EN
         if (c == TC) begin
            chk("t6_err", 32'(m_error_out), 32'h1);
            chk("t6_ready", 32'(m_ready_out), 32'h2);
            chk("t6_rvalue", m_read_value_out, 32'hFFFF_FFFF);
         end
`else
         if (c == TC) begin
            chk("t6_noto_ready", 32'(m_ready_out), 32'h0);
            chk("t6_noto_err", 32'(m_error_out), 32'h0);
         end
         if (c == 110) begin
            chk("t6_hung_read", 32'(read_out), 32'h1);
            chk("t6_hung_addr", address_out, 32'h50);
         end
`endif
      end
      tick();
      ready_in = 1'b1;
      tick();
      set_m(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      ready_in = 1'b0;
      tick(); tick();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
